// File: rtl/pulse_stretch_pkg.sv
// Shared constants and helpers for the pulse stretcher.
// Feature macro used elsewhere: PULSE_STRETCH_RETRIGGER_EN.
package pulse_stretch_pkg;

    localparam int DEFAULT_STRETCH_CYCLES = 2500000;
    localparam int DEFAULT_CHANNELS       = 4;

    // The counter must be able to hold STRETCH_CYCLES itself, so size it for cycles+1 states.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/stretch_channel.sv
// One stretcher channel: down-counter, stretched level and overrun flag.
// Define PULSE_STRETCH_RETRIGGER_EN to reload the counter on pulses that arrive while active.
module stretch_channel
    import pulse_stretch_pkg::*;
#(
    parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic pulse_in,
    output logic pulse_out,
    output logic overrun,
    output logic active_next
);

    localparam int CW = cnt_width(STRETCH_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          overrun_next;

    always_comb begin
        count_next   = count;
        overrun_next = 1'b0;
        if (count == '0) begin
            if (pulse_in) begin
                count_next = LOAD;
            end
        end else begin
            // Any pulse on the final active cycle still counts as an overrun.
            overrun_next = pulse_in;
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (pulse_in) begin
                count_next = LOAD;
            end else begin
                count_next = count - CW'(1);
            end
`else
            count_next = count - CW'(1);
`endif
        end
    end

    assign active_next = (count_next != '0);

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            count     <= '0;
            pulse_out <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            count     <= count_next;
            pulse_out <= active_next;
            overrun   <= overrun_next;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher with a registered busy summary.
// Retrigger behaviour is selected by the PULSE_STRETCH_RETRIGGER_EN macro.
module pulse_stretcher
    import pulse_stretch_pkg::*;
#(
    parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int CHANNELS       = DEFAULT_CHANNELS
) (
    input  logic                CLK50MHZ,
    input  logic                RST,
    input  logic [CHANNELS-1:0] pulse_in,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] overrun,
    output logic                busy
);

    logic [CHANNELS-1:0] active_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        stretch_channel #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_channel (
            .CLK50MHZ   (CLK50MHZ),
            .RST        (RST),
            .pulse_in   (pulse_in[i]),
            .pulse_out  (pulse_out[i]),
            .overrun    (overrun[i]),
            .active_next(active_next[i])
        );
    end

    // Built from the channels' next values so busy lands on the same edge as pulse_out.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            busy <= 1'b0;
        end else begin
            busy <= |active_next;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed plus randomized bench for pulse_stretcher against an end-time reference model.
module tb_pulse_stretcher;

    localparam int S     = 4;
    localparam int CH    = 4;
    localparam int TOTAL = 600;

    logic          CLK50MHZ = 1'b0;
    logic          RST      = 1'b1;
    logic [CH-1:0] pulse_in = '0;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cur_cycle = 0;

    // Model: last cycle each channel is high, and the overrun expected next cycle.
    int       end_cycle [CH];
    logic     ov_exp    [CH];

    always #10 CLK50MHZ = ~CLK50MHZ;

    pulse_stretcher #(
        .STRETCH_CYCLES(S),
        .CHANNELS      (CH)
    ) dut (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .pulse_in (pulse_in),
        .pulse_out(pulse_out),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cur_cycle, observed, expected);
        end
    endtask

    // Directed scenarios for edges below 60, random pulses and occasional resets after.
    task automatic applyStimulus(input int n);
        logic [CH-1:0] p;
        logic          r;
        p = '0;
        r = 1'b0;
        if (n < 60) begin
            case (n)
                0, 1, 2: r = 1'b1;
                10:      p = 4'b0011;
                12:      p = 4'b0010;
                20:      p = 4'b1111;
                30, 31, 32: p = 4'b0100;
                40:      p = 4'b1000;
                42:      begin r = 1'b1; p = 4'b1111; end
                45:      p = 4'b1000;
                50, 54:  p = 4'b0001;
                default: p = '0;
            endcase
        end else begin
            for (int i = 0; i < CH; i++) p[i] = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 49) == 0);
        end
        RST      = r;
        pulse_in = p;
    endtask

    initial begin
        logic [CH-1:0] exp_out;
        logic [CH-1:0] exp_ov;
        int c;
        for (int i = 0; i < CH; i++) begin
            end_cycle[i] = -1;
            ov_exp[i]    = 1'b0;
        end
        for (int n = 0; n < TOTAL; n++) begin
            @(negedge CLK50MHZ);
            applyStimulus(n);
            @(posedge CLK50MHZ);
            #1;
            c = n + 1;
            cur_cycle = c;
            for (int i = 0; i < CH; i++) begin
                ov_exp[i] = 1'b0;
                if (RST) begin
                    end_cycle[i] = n;
                end else if (pulse_in[i]) begin
                    if (end_cycle[i] >= n) begin
                        ov_exp[i] = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
                        end_cycle[i] = n + S;
`endif
                    end else begin
                        end_cycle[i] = n + S;
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                exp_out[i] = (c <= end_cycle[i]);
                exp_ov[i]  = ov_exp[i];
            end
            checkOutput("pulse_out", 32'(pulse_out), 32'(exp_out));
            checkOutput("overrun",   32'(overrun),   32'(exp_ov));
            checkOutput("busy",      32'(busy),      32'(|exp_out));

            // Hand-derived timeline points independent of the retrigger setting.
            if (c == 1) checkOutput("reset_state", 32'({pulse_out, overrun, busy}), 32'd0);
            if (c >= 11 && c <= 14) checkOutput("single_ch0_high", 32'(pulse_out[0]), 32'd1);
            if (c == 15) checkOutput("single_ch0_low", 32'(pulse_out[0]), 32'd0);
            if (c == 13) checkOutput("retrig_ov1", 32'(overrun[1]), 32'd1);
            if (c == 14) checkOutput("retrig_ov1_clear", 32'(overrun[1]), 32'd0);
            if (c >= 21 && c <= 24) checkOutput("all_ch_high", 32'(pulse_out), 32'hF);
            if (c == 25) checkOutput("all_ch_low", 32'(pulse_out), 32'h0);
            if (c == 32 || c == 33) checkOutput("held_ov2", 32'(overrun[2]), 32'd1);
            if (c == 43) checkOutput("reset_abort", 32'({pulse_out, overrun, busy}), 32'd0);
            if (c >= 46 && c <= 49) checkOutput("post_reset_ch3", 32'(pulse_out[3]), 32'd1);
            if (c == 50) checkOutput("post_reset_ch3_low", 32'(pulse_out[3]), 32'd0);
            if (c == 55) checkOutput("last_cycle_ov0", 32'(overrun[0]), 32'd1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (c == 16) checkOutput("retrig_ch1_end", 32'(pulse_out[1]), 32'd1);
            if (c == 17) checkOutput("retrig_ch1_off", 32'(pulse_out[1]), 32'd0);
            if (c == 58) checkOutput("last_cycle_ch0_ext", 32'(pulse_out[0]), 32'd1);
            if (c == 59) checkOutput("last_cycle_ch0_off", 32'(pulse_out[0]), 32'd0);
`else
            if (c == 14) checkOutput("norm_ch1_end", 32'(pulse_out[1]), 32'd1);
            if (c == 15) checkOutput("norm_ch1_off", 32'(pulse_out[1]), 32'd0);
            if (c == 55) checkOutput("last_cycle_ch0_off", 32'(pulse_out[0]), 32'd0);
`endif
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
